// File: rtl/pipelined_adder.sv
// ---------------------------------------------------------------------------
// pipelined_adder
//
// Pipelined two's-complement adder/subtractor with a valid/ready handshake.
// The WIDTH-bit carry chain is split into STAGES slices of S = WIDTH/STAGES
// bits. Stage k adds slice k using the carry registered by stage k-1. The
// whole pipe advances together on en = !oValid | iReady, so any downstream
// stall freezes every stage and no bubbles are collapsed.
//
// Each stage register carries one "word": slices below and including the
// stage's own slice hold finished sum bits (de-skew), slices above it still
// hold operand A (skew). Operand B' (already inverted for subtraction)
// travels alongside in its own skew register.
//
// Optional feature macro: PIPELINED_ADDER_FLAGS_EN
//   defined   : oOverflow / oZero are computed in the final stage and
//               registered with oSum.
//   undefined : oOverflow and oZero are tied to 0 and no flag logic exists.
//
// Parameters
//   WIDTH     operand/result width, must be a multiple of STAGES
//   STAGES    pipeline depth and carry-slice count, 1..WIDTH
// Ports
//   iClk        clock, rising edge
//   iRst_n      asynchronous active-low reset
//   iValid      operand beat valid
//   oReady      beat can be accepted this cycle (= en)
//   iA, iB      operands
//   iC          carry-in, ignored when iSub = 1
//   iSub        1 = A - B
//   oValid      result beat valid
//   iReady      downstream accepts result
//   oSum        result
//   oCarryout   carry out of the msb (subtraction: 1 = no borrow)
//   oOverflow   signed overflow flag
//   oZero       oSum == 0 flag
// ---------------------------------------------------------------------------
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iValid,
    output logic             oReady,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iC,
    input  logic             iSub,
    output logic             oValid,
    input  logic             iReady,
    output logic [WIDTH-1:0] oSum,
    output logic             oCarryout,
    output logic             oOverflow,
    output logic             oZero
);

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipelined_adder: WIDTH (%0d) must be a multiple of STAGES (%0d), 1 <= STAGES <= WIDTH",
               WIDTH, STAGES);
    end

    localparam int S = WIDTH / STAGES;

    // Pipeline registers, index k = output of stage k.
    logic             valid_q [STAGES];
    logic             carry_q [STAGES];
    logic [WIDTH-1:0] word_q  [STAGES];
    logic [WIDTH-1:0] opb_q   [STAGES];

    // Per-stage inputs and next-state values.
    logic             valid_in [STAGES];
    logic             carry_in [STAGES];
    logic [WIDTH-1:0] word_in  [STAGES];
    logic [WIDTH-1:0] opb_in   [STAGES];
    logic             carry_d  [STAGES];
    logic [WIDTH-1:0] word_d   [STAGES];

    logic en;

    assign en     = !valid_q[STAGES-1] | iReady;
    assign oReady = en;

    // Stage 0 takes the effective operands; subtraction is A + ~B + 1.
    assign valid_in[0] = iValid;
    assign word_in[0]  = iA;
    assign opb_in[0]   = iSub ? ~iB : iB;
    assign carry_in[0] = iSub | iC;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [S:0]       slice_sum;
        logic [WIDTH-1:0] merged;

        if (k > 0) begin : g_link
            assign valid_in[k] = valid_q[k-1];
            assign word_in[k]  = word_q[k-1];
            assign opb_in[k]   = opb_q[k-1];
            assign carry_in[k] = carry_q[k-1];
        end

        assign slice_sum = {1'b0, word_in[k][k*S +: S]}
                         + {1'b0, opb_in[k][k*S +: S]}
                         + {{S{1'b0}}, carry_in[k]};

        // NOTE: always_comb starts from a full default and then overrides one
        // slice with blocking '=' so the result is never a latch.
        always_comb begin
            merged            = word_in[k];
            merged[k*S +: S]  = slice_sum[S-1:0];
        end

        assign word_d[k]  = merged;
        assign carry_d[k] = slice_sum[S];
    end

    // NOTE: the datapath registers are reset too (not only the valid bits)
    // because oSum/oCarryout must read 0 while reset is asserted.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                carry_q[k] <= 1'b0;
                word_q[k]  <= '0;
                opb_q[k]   <= '0;
            end
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= valid_in[k];
                carry_q[k] <= carry_d[k];
                word_q[k]  <= word_d[k];
                opb_q[k]   <= opb_in[k];
            end
        end
    end

    assign oValid    = valid_q[STAGES-1];
    assign oSum      = word_q[STAGES-1];
    assign oCarryout = carry_q[STAGES-1];

`ifdef PIPELINED_ADDER_FLAGS_EN
    // The final stage still sees the original A msb and B' msb on its input,
    // so the classic same-sign-in / different-sign-out test applies directly.
    logic a_msb;
    logic b_msb;
    logic ovf_d;
    logic zero_d;
    logic ovf_q;
    logic zero_q;

    assign a_msb  = word_in[STAGES-1][WIDTH-1];
    assign b_msb  = opb_in[STAGES-1][WIDTH-1];
    assign ovf_d  = (a_msb == b_msb) && (word_d[STAGES-1][WIDTH-1] != a_msb);
    assign zero_d = (word_d[STAGES-1] == '0);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (en) begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign oOverflow = ovf_q;
    assign oZero     = zero_q;
`else
    assign oOverflow = 1'b0;
    assign oZero     = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// ---------------------------------------------------------------------------
// tb_pipelined_adder
//
// Self-checking bench for pipelined_adder. A WIDTH=32/STAGES=4 instance is
// exercised with directed corner cases, a backpressure sequence, a mid-stream
// reset and a randomized run checked against an arithmetic scoreboard.
// A second WIDTH=16/STAGES=1 instance covers the single-stage build.
// Flag expectations follow PIPELINED_ADDER_FLAGS_EN as compiled.
// ---------------------------------------------------------------------------
module tb_pipelined_adder;

`ifdef PIPELINED_ADDER_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, sum;
    logic        cin, sub, cout, ovf, zero;

    logic        in_valid1, in_ready1, out_valid1, out_ready1;
    logic [15:0] a1, b1, sum1;
    logic        cin1, sub1, cout1, ovf1, zero1;

    int   checks = 0;
    int   errors = 0;
    int   delivered = 0;
    res_t exp_q[$];

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
        .iClk(clk), .iRst_n(rst_n),
        .iValid(in_valid), .oReady(in_ready),
        .iA(a), .iB(b), .iC(cin), .iSub(sub),
        .oValid(out_valid), .iReady(out_ready),
        .oSum(sum), .oCarryout(cout), .oOverflow(ovf), .oZero(zero)
    );

    pipelined_adder #(.WIDTH(16), .STAGES(1)) dut1 (
        .iClk(clk), .iRst_n(rst_n),
        .iValid(in_valid1), .oReady(in_ready1),
        .iA(a1), .iB(b1), .iC(cin1), .iSub(sub1),
        .oValid(out_valid1), .iReady(out_ready1),
        .oSum(sum1), .oCarryout(cout1), .oOverflow(ovf1), .oZero(zero1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain wide arithmetic, signed range test for overflow.
    function automatic res_t model(input logic [31:0] ma, input logic [31:0] mb,
                                   input logic mc, input logic msub);
        res_t        r;
        logic [31:0] bp;
        logic        ci;
        logic [32:0] full;
        longint      s;
        bp     = msub ? ~mb : mb;
        ci     = msub ? 1'b1 : mc;
        full   = {1'b0, ma} + {1'b0, bp} + {32'd0, ci};
        s      = longint'($signed(ma)) + longint'($signed(bp)) + longint'(ci);
        r.sum  = full[31:0];
        r.cout = full[32];
        r.ovf  = FLAGS && ((s > 64'sd2147483647) || (s < -64'sd2147483648));
        r.zero = FLAGS && (full[31:0] == 32'd0);
        return r;
    endfunction

    // One clock: inputs are already set (at or just after negedge).
    task automatic tick();
        res_t e;
        if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
        if (out_valid && !out_ready) check("stall_oready", in_ready, 1'b0);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("sum", sum, e.sum);
                check("cout", cout, e.cout);
                check("ovf", ovf, e.ovf);
                check("zero", zero, e.zero);
                delivered++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Single isolated beat with explicit expected values and latency.
    task automatic run_one(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                           input logic tc, input logic tsub, input logic [31:0] esum,
                           input logic ecout, input logic eovf, input logic ezero);
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = ta; b = tb_; cin = tc; sub = tsub;
        #1;
        check({tag, "_ready"}, in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 32'hDEAD_BEEF; b = 32'h1234_5678; cin = 1'b1; sub = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, "_latency"}, lat, 4);
        check({tag, "_sum"}, sum, esum);
        check({tag, "_cout"}, cout, ecout);
        check({tag, "_ovf"}, ovf, FLAGS & eovf);
        check({tag, "_zero"}, zero, FLAGS & ezero);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_drained"}, out_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int   base, sent;
        bit   have_snap;
        res_t snap;
        logic [31:0] pick [4];

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
        pick[0] = 32'h0000_0000; pick[1] = 32'hFFFF_FFFF;
        pick[2] = 32'h8000_0000; pick[3] = 32'h7FFF_FFFF;

        // Reset state.
        #12;
        check("rst_valid", out_valid, 1'b0);
        check("rst_sum", sum, 32'd0);
        check("rst_cout", cout, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", in_ready, 1'b1);
        check("post_rst_valid", out_valid, 1'b0);

        // Directed corner cases.
        run_one("carry_chain", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_one("sub_7_5",     32'd7, 32'd5, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
        run_one("sub_5_7",     32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_one("ovf_pos",     32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_one("ovf_neg",     32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

        // Backpressure: 10 beats, downstream stalls 3 cycles mid-stream.
        base = delivered;
        sent = 0;
        have_snap = 1'b0;
        for (int cyc = 0; cyc < 60 && (delivered - base) < 10; cyc++) begin
            out_ready = !(cyc >= 6 && cyc < 9);
            #1;
            cin = 1'b0; sub = 1'b0;
            if (sent < 10) begin
                in_valid = 1'b1;
                if (in_ready) begin
                    a = 32'(sent + 1);
                    b = 32'(32'h100 * (sent + 1));
                end else begin
                    a = 32'hBAD0_0000 + 32'(cyc);
                    b = 32'h0BAD_0000;
                end
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) begin
                if (have_snap) begin
                    check("frozen_sum", sum, snap.sum);
                    check("frozen_flags", {cout, ovf, zero}, {snap.cout, snap.ovf, snap.zero});
                end
                snap = '{sum: sum, cout: cout, ovf: ovf, zero: zero};
                have_snap = 1'b1;
            end else begin
                have_snap = 1'b0;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        check("bp_delivered", delivered - base, 10);
        check("bp_queue_empty", exp_q.size(), 0);

        // Randomized traffic with random backpressure.
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a   = ($urandom_range(0, 4) == 0) ? pick[$urandom_range(0, 3)] : $urandom;
            b   = ($urandom_range(0, 4) == 0) ? pick[$urandom_range(0, 3)] : $urandom;
            cin = 1'($urandom);
            sub = 1'($urandom);
            #1;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) tick();
        check("rand_queue_empty", exp_q.size(), 0);

        // Reset with beats in flight, asserted between clock edges.
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            a = 32'h1111_0000 + 32'(i); b = 32'h0000_0100; cin = 1'b1; sub = 1'b0;
            tick();
        end
        check("pre_rst_valid", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_sum", sum, 32'd0);
        check("midrst_flags", {cout, ovf, zero}, 3'b000);
        exp_q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ready", in_ready, 1'b1);
        for (int cyc = 0; cyc < 8; cyc++) begin
            check("no_stale", out_valid, 1'b0);
            tick();
        end

        // Single-stage, 16-bit instance: latency 1.
        in_valid1 = 1'b1; a1 = 16'h1234; b1 = 16'h0FFF; cin1 = 1'b1; sub1 = 1'b0;
        @(posedge clk);
        #1 in_valid1 = 1'b0;
        @(negedge clk);
        check("s1_valid", out_valid1, 1'b1);
        check("s1_sum", sum1, 16'h2234);
        check("s1_cout", cout1, 1'b0);
        check("s1_flags", {ovf1, zero1}, 2'b00);
        @(posedge clk);
        @(negedge clk);
        check("s1_drained", out_valid1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
